// File: rtl/short_pulse_checker_if.sv
// rtl/short_pulse_checker_if.sv - control and status bundle of the short-pulse checker
//   master: drives enable, pulse_in, clear_err; observes the status outputs
//   slave : the checker; samples the controls, drives pulse_ok, locked,
//           width_err, period_err, timeout_err, last_period, good_count
interface short_pulse_checker_if #(
    parameter int CNT_W = 16
) ();
    logic             enable;
    logic             pulse_in;
    logic             clear_err;
    logic             pulse_ok;
    logic             locked;
    logic             width_err;
    logic             period_err;
    logic             timeout_err;
    logic [7:0]       last_period;
    logic [CNT_W-1:0] good_count;

    modport master (
        output enable, pulse_in, clear_err,
        input  pulse_ok, locked, width_err, period_err, timeout_err,
               last_period, good_count
    );

    modport slave (
        input  enable, pulse_in, clear_err,
        output pulse_ok, locked, width_err, period_err, timeout_err,
               last_period, good_count
    );
endinterface

// File: rtl/short_pulse_checker.sv
// rtl/short_pulse_checker.sv - short-pulse width/period monitor with lock detection
//   clk  : clock, all logic on posedge
//   rst  : asynchronous active-high reset
//   bus  : slave side of short_pulse_checker_if (enable, pulse_in, clear_err in;
//          pulse_ok, locked, sticky errors, last_period, good_count out)
module short_pulse_checker #(
    parameter int EXP_WIDTH  = 1,
    parameter int EXP_PERIOD = 11,
    parameter int PERIOD_TOL = 0,
    parameter int LOCK_COUNT = 3,
    parameter int TIMEOUT    = 32,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    short_pulse_checker_if.slave bus
);
    localparam logic [7:0] EW8  = 8'(EXP_WIDTH);
    localparam logic [7:0] EP8  = 8'(EXP_PERIOD);
    localparam logic [7:0] TOL8 = 8'(PERIOD_TOL);
    localparam logic [7:0] TO8  = 8'(TIMEOUT);
    localparam logic [3:0] LC4  = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, HUNT, TRACK, LOCKED} state_t;

    state_t           state, state_nx;
    logic             pulse_q;
    logic [7:0]       wcnt, pcnt;
    logic [3:0]       cg;
    logic             ref_next;   // next rising edge starts a fresh period reference
    logic             per_good;   // period verdict of the current pulse, held until F
    logic             pulse_ok_r, locked_r, werr_r, perr_r, terr_r;
    logic [7:0]       last_period_r;
    logic [CNT_W-1:0] good_count_r;

    logic       rise, fall, active, in_tol, width_good, pulse_good, timeout_hit;
    logic [7:0] period_meas, dev;
    logic [3:0] cg_inc;
    logic       ok_d, set_w, set_p, set_t;

    assign rise        = bus.pulse_in & ~pulse_q;
    assign fall        = ~bus.pulse_in & pulse_q;
    assign active      = (state == TRACK) || (state == LOCKED);
    assign period_meas = (pcnt == 8'hFF) ? 8'hFF : pcnt + 8'd1;
    assign dev         = (period_meas >= EP8) ? period_meas - EP8 : EP8 - period_meas;
    assign in_tol      = dev <= TOL8;
    assign width_good  = wcnt == EW8;
    assign pulse_good  = width_good && per_good;
    // period_meas is the period a rising edge in this cycle would measure;
    // reaching TIMEOUT without that edge means the signal is lost
    assign timeout_hit = active && !rise && (period_meas >= TO8);
    assign cg_inc      = (cg == 4'hF) ? 4'hF : cg + 4'd1;

    always_comb begin
        state_nx = state;
        ok_d     = 1'b0;
        set_w    = 1'b0;
        set_p    = 1'b0;
        set_t    = 1'b0;
        if (!bus.enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: state_nx = HUNT;
                HUNT: if (rise) state_nx = TRACK;
                TRACK, LOCKED: begin
                    if (timeout_hit) begin
                        state_nx = HUNT;
                        set_t    = 1'b1;
                    end else if (fall) begin
                        if (pulse_good) begin
                            ok_d = 1'b1;
                            if (cg_inc >= LC4) state_nx = LOCKED;
                        end else begin
                            state_nx = TRACK;
                            set_w    = !width_good;
                            set_p    = !per_good;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pulse_q       <= 1'b0;
            wcnt          <= '0;
            pcnt          <= '0;
            cg            <= '0;
            ref_next      <= 1'b0;
            per_good      <= 1'b0;
            pulse_ok_r    <= 1'b0;
            locked_r      <= 1'b0;
            werr_r        <= 1'b0;
            perr_r        <= 1'b0;
            terr_r        <= 1'b0;
            last_period_r <= '0;
            good_count_r  <= '0;
        end else begin
            state      <= state_nx;
            pulse_q    <= bus.pulse_in;
            locked_r   <= (state_nx == LOCKED);
            pulse_ok_r <= ok_d;
            if (ok_d) good_count_r <= good_count_r + CNT_W'(1);
            // a new error in the same cycle as clear_err survives the clear
            werr_r <= set_w | (werr_r & ~bus.clear_err);
            perr_r <= set_p | (perr_r & ~bus.clear_err);
            terr_r <= set_t | (terr_r & ~bus.clear_err);

            if (!bus.enable || state == IDLE) begin
                wcnt     <= '0;
                pcnt     <= '0;
                cg       <= '0;
                ref_next <= 1'b0;
                per_good <= 1'b0;
            end else begin
                if (rise)
                    wcnt <= 8'd1;
                else if (bus.pulse_in && pulse_q && wcnt != 8'hFF)
                    wcnt <= wcnt + 8'd1;

                if (rise)
                    pcnt <= '0;
                else if (pcnt != 8'hFF)
                    pcnt <= pcnt + 8'd1;

                if (state == HUNT && rise) begin
                    per_good <= 1'b1;
                    ref_next <= 1'b0;
                    cg       <= '0;
                end
                if (active && rise) begin
                    last_period_r <= period_meas;
                    per_good      <= ref_next | in_tol;
                    ref_next      <= 1'b0;
                end
                if (set_t) cg <= '0;
                if (ok_d)  cg <= cg_inc;
                if (active && fall && !timeout_hit && !pulse_good) begin
                    cg       <= '0;
                    ref_next <= 1'b1;
                end
            end
        end
    end

    assign bus.pulse_ok    = pulse_ok_r;
    assign bus.locked      = locked_r;
    assign bus.width_err   = werr_r;
    assign bus.period_err  = perr_r;
    assign bus.timeout_err = terr_r;
    assign bus.last_period = last_period_r;
    assign bus.good_count  = good_count_r;
endmodule

// File: tb/tb_short_pulse_checker.sv
// tb/tb_short_pulse_checker.sv - self-checking bench for short_pulse_checker
module tb_short_pulse_checker;
    localparam int M_EXP_W  = 1;
    localparam int M_EXP_P  = 11;
    localparam int M_TOL    = 0;
    localparam int M_LOCK   = 3;
    localparam int M_TO     = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    short_pulse_checker_if #(.CNT_W(16)) bus0 ();
    short_pulse_checker_if #(.CNT_W(16)) bus1 ();
    assign bus1.enable    = bus0.enable;
    assign bus1.pulse_in  = bus0.pulse_in;
    assign bus1.clear_err = bus0.clear_err;

    short_pulse_checker #(.PERIOD_TOL(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    short_pulse_checker #(.PERIOD_TOL(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_total++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    // behavioural reference: timestamps of edges instead of counters
    int          m_cyc = 0, m_st = 0, m_lastr = 0, m_rcyc = 0, m_cg = 0;
    bit          m_prev = 0, m_ref = 0, m_pg = 0;
    bit          e_pok = 0, e_lock = 0, e_werr = 0, e_perr = 0, e_terr = 0;
    logic [7:0]  e_lp = 0;
    logic [15:0] e_gc = 0;

    task automatic model_step();
        bit pin, en, clr, rise, fall, sw, sp, stt;
        int per, dev, w;
        if (rst) begin
            m_st = 0; m_prev = 0; m_cg = 0; m_ref = 0; m_pg = 0;
            e_pok = 0; e_lock = 0; e_werr = 0; e_perr = 0; e_terr = 0;
            e_lp = 0; e_gc = 0;
        end else begin
            pin = bus0.pulse_in; en = bus0.enable; clr = bus0.clear_err;
            rise = pin && !m_prev;
            fall = !pin && m_prev;
            sw = 0; sp = 0; stt = 0; e_pok = 0;
            if (!en) begin
                m_st = 0; m_cg = 0; m_ref = 0; m_pg = 0;
            end else if (m_st == 0) begin
                m_st = 1;
            end else if (m_st == 1) begin
                if (rise) begin
                    m_st = 2; m_lastr = m_cyc; m_rcyc = m_cyc; m_pg = 1; m_ref = 0; m_cg = 0;
                end
            end else begin
                if (rise) begin
                    per = m_cyc - m_lastr;
                    if (per > 255) per = 255;
                    e_lp = 8'(per);
                    dev = per - M_EXP_P;
                    if (dev < 0) dev = -dev;
                    m_pg = m_ref || (dev <= M_TOL);
                    m_ref = 0; m_lastr = m_cyc; m_rcyc = m_cyc;
                end else if (m_cyc - m_lastr >= M_TO) begin
                    stt = 1; m_st = 1; m_cg = 0;
                end else if (fall) begin
                    w = m_cyc - m_rcyc;
                    if (w == M_EXP_W && m_pg) begin
                        e_pok = 1; e_gc++;
                        if (m_cg < 15) m_cg++;
                        if (m_cg >= M_LOCK) m_st = 3;
                    end else begin
                        sw = (w != M_EXP_W); sp = !m_pg;
                        m_st = 2; m_cg = 0; m_ref = 1;
                    end
                end
            end
            e_werr = sw  || (e_werr && !clr);
            e_perr = sp  || (e_perr && !clr);
            e_terr = stt || (e_terr && !clr);
            e_lock = (m_st == 3);
            m_prev = pin;
        end
        m_cyc++;
    endtask

    function automatic logic [28:0] dut_pack();
        return {bus0.pulse_ok, bus0.locked, bus0.width_err, bus0.period_err,
                bus0.timeout_err, bus0.last_period, bus0.good_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk($sformatf("model cycle %0d {ok,lk,we,pe,te,lp,gc}", m_cyc), 64'(dut_pack()),
            64'({e_pok, e_lock, e_werr, e_perr, e_terr, e_lp, e_gc}));
    endtask

    // low cycles, high cycles, then one falling-edge cycle (clear_err applied there)
    task automatic pulse(input int low, input int w, input bit clr);
        bus0.pulse_in = 1'b0;
        repeat (low) tick();
        bus0.pulse_in = 1'b1;
        repeat (w) tick();
        bus0.pulse_in  = 1'b0;
        bus0.clear_err = clr;
        tick();
        bus0.clear_err = 1'b0;
    endtask

    typedef struct {
        int low; int w; bit clr;
        bit pok; bit lock; bit werr; bit perr; bit terr;
        int lp; int gc;
    } vec_t;
    vec_t tbl[17];

    function automatic vec_t mk(int low, int w, bit clr, bit pok, bit lock, bit werr,
                                bit perr, bit terr, int lp, int gc);
        vec_t v;
        v.low = low; v.w = w; v.clr = clr; v.pok = pok; v.lock = lock;
        v.werr = werr; v.perr = perr; v.terr = terr; v.lp = lp; v.gc = gc;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(3, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        tbl[1]  = mk(9, 1, 0, 1, 0, 0, 0, 0, 11, 2);
        tbl[2]  = mk(9, 1, 0, 1, 1, 0, 0, 0, 11, 3);
        tbl[3]  = mk(9, 1, 0, 1, 1, 0, 0, 0, 11, 4);
        tbl[4]  = mk(9, 1, 0, 1, 1, 0, 0, 0, 11, 5);
        tbl[5]  = mk(9, 2, 0, 0, 0, 1, 0, 0, 11, 5);
        tbl[6]  = mk(8, 1, 0, 1, 0, 1, 0, 0, 11, 6);
        tbl[7]  = mk(9, 1, 0, 1, 0, 1, 0, 0, 11, 7);
        tbl[8]  = mk(9, 1, 0, 1, 1, 1, 0, 0, 11, 8);
        tbl[9]  = mk(9, 2, 1, 0, 0, 1, 0, 0, 11, 8);
        tbl[10] = mk(8, 1, 1, 1, 0, 0, 0, 0, 11, 9);
        tbl[11] = mk(9, 1, 0, 1, 0, 0, 0, 0, 11, 10);
        tbl[12] = mk(9, 1, 0, 1, 1, 0, 0, 0, 11, 11);
        tbl[13] = mk(10, 1, 0, 0, 0, 0, 1, 0, 12, 11);
        tbl[14] = mk(9, 1, 0, 1, 0, 0, 1, 0, 11, 12);
        tbl[15] = mk(9, 1, 0, 1, 0, 0, 1, 0, 11, 13);
        tbl[16] = mk(9, 1, 0, 1, 1, 0, 1, 0, 11, 14);

        rst = 1'b1;
        bus0.enable = 1'b0; bus0.pulse_in = 1'b0; bus0.clear_err = 1'b0;
        tick(); tick();
        chk("reset outputs", 64'(dut_pack()), 64'd0);
        rst = 1'b0;
        tick();
        bus0.enable = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            pulse(tbl[i].low, tbl[i].w, tbl[i].clr);
            chk($sformatf("row %0d {ok,lk,we,pe,te}", i),
                64'({bus0.pulse_ok, bus0.locked, bus0.width_err, bus0.period_err, bus0.timeout_err}),
                64'({tbl[i].pok, tbl[i].lock, tbl[i].werr, tbl[i].perr, tbl[i].terr}));
            chk($sformatf("row %0d last_period", i), 64'(bus0.last_period), 64'(tbl[i].lp));
            chk($sformatf("row %0d good_count", i), 64'(bus0.good_count), 64'(tbl[i].gc));
        end
        chk("tol1 period_err", 64'(bus1.period_err), 64'd0);
        chk("tol1 locked", 64'(bus1.locked), 64'd1);
        chk("tol1 good_count", 64'(bus1.good_count), 64'd15);

        // loss of signal: observing cycle R+2 now
        repeat (30) tick();
        chk("timeout_err before R+33", 64'(bus0.timeout_err), 64'd0);
        tick();
        chk("timeout_err at R+33", 64'(bus0.timeout_err), 64'd1);
        chk("locked after timeout", 64'(bus0.locked), 64'd0);
        pulse(5, 1, 0);
        chk("reference after timeout ok", 64'({bus0.pulse_ok, bus0.locked}), 64'b10);
        chk("good_count after timeout", 64'(bus0.good_count), 64'd15);
        pulse(9, 1, 0);
        pulse(9, 1, 0);
        chk("relock after timeout", 64'(bus0.locked), 64'd1);

        // enable dropped mid-stream
        bus0.enable = 1'b0;
        tick();
        chk("disable locked", 64'(bus0.locked), 64'd0);
        chk("disable good_count held", 64'(bus0.good_count), 64'd17);
        tick(); tick();
        bus0.enable = 1'b1;
        tick();
        pulse(3, 1, 0); pulse(9, 1, 0); pulse(9, 1, 0);
        chk("re-enable lock", 64'({bus0.locked, bus0.good_count}), 64'({1'b1, 16'd20}));

        // randomized pulse trains against the model
        for (int n = 0; n < 300; n++) begin
            int low, w, r;
            bit clr;
            r = $urandom_range(0, 99);
            if (r < 55)      begin low = 9;  w = 1; end
            else if (r < 90) begin low = $urandom_range(0, 12); w = $urandom_range(1, 3); end
            else             begin low = $urandom_range(30, 40); w = 1; end
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 29) == 0) begin
                bus0.enable = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
                bus0.enable = 1'b1;
            end
            pulse(low, w, clr);
        end

        // asynchronous reset in the middle of a pulse
        pulse(9, 1, 0);
        bus0.pulse_in = 1'b1;
        tick(); tick();
        #2 rst = 1'b1;
        #1 chk("async reset outputs", 64'(dut_pack()), 64'd0);
        tick();
        rst = 1'b0;
        bus0.pulse_in = 1'b0;
        tick();
        pulse(3, 1, 0); pulse(9, 1, 0); pulse(9, 1, 0);
        chk("lock after reset", 64'({bus0.locked, bus0.good_count}), 64'({1'b1, 16'd3}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/short_pulse_checker.md
# short_pulse_checker

Receive-side monitor for the short-pulse interface. It samples a single-bit pulse train and measures the high width of each pulse and the rising-to-rising period. It qualifies every pulse against programmed limits, reports per-pulse strobes and sticky errors, and declares lock after a run of consecutive good pulses. It sits on the same clock as the pulse source and feeds status and interrupt logic.

## Interface
- EXP_WIDTH, 1: expected high width in clk cycles (1..255).
- EXP_PERIOD, 11: expected rising-to-rising period in cycles (2..255). 11 matches a short-pulse source with start held continuously.
- PERIOD_TOL, 0: allowed ± deviation of the measured period.
- LOCK_COUNT, 3: consecutive good pulses needed to lock (1..15).
- TIMEOUT, 32: cycles without a rising edge that count as loss of signal (> EXP_PERIOD+PERIOD_TOL, ≤ 255).
- CNT_W, 16: width of good_count.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  0 forces IDLE.
- pulse_in  in  1  pulse train, synchronous to clk.
- clear_err  in  1  one-cycle clear of the sticky error flags.
- pulse_ok  out  1  one-cycle strobe per qualified pulse.
- locked  out  1  high while in state LOCKED.
- width_err  out  1  sticky: a pulse width was out of spec.
- period_err  out  1  sticky: a period was out of spec.
- timeout_err  out  1  sticky: loss of signal.
- last_period  out  8  last measured period, saturating at 255.
- good_count  out  CNT_W  count of pulse_ok strobes; wraps modulo 2^CNT_W.

## Operation
- Reset: all outputs 0, state IDLE, pulse_q=0, internal counters 0.
- pulse_q is pulse_in registered once.
- A rising edge R is a cycle with pulse_in=1 and pulse_q=0.
- A falling edge F is a cycle with pulse_in=0 and pulse_q=1.
- States:
  - IDLE: entered whenever enable=0, from any state.
  - HUNT: waiting for the first rising edge; no checks are made.
  - TRACK: measuring pulses, not yet locked.
  - LOCKED: locked to the pulse train.
- Transitions:
  - IDLE→HUNT when enable=1.
  - HUNT→TRACK on R. This pulse becomes the period reference and gets no period check.
- Width counter (8 bits, saturating):
  - Loads 1 on R.
  - Increments each cycle pulse_in stays high.
  - Its value at F is the measured width. The width is good when it equals EXP_WIDTH.
- Period counter (8 bits, saturating):
  - Loads 0 on R and increments on every other cycle.
  - At R, the measured period is counter+1. That value is written to last_period and checked against |period−EXP_PERIOD| ≤ PERIOD_TOL.
  - The result is held in a pending flag until F.
- Pulse evaluation at F, in TRACK or LOCKED:
  - Good pulse: width good and (period good, or this is the reference pulse after HUNT or after an error).
  - On a good pulse: pulse_ok=1 for one cycle, good_count+1, consecutive-good count+1.
  - When the consecutive-good count reaches LOCK_COUNT: TRACK→LOCKED.
  - On a bad pulse: set width_err and/or period_err, go to TRACK, clear the consecutive-good count. The next R becomes the new period reference.
- Timeout: in TRACK or LOCKED, when the period counter reaches TIMEOUT with no R, set timeout_err, go to HUNT, clear the consecutive-good count.
- A pulse still high at TIMEOUT produces the same timeout.
- enable=0: state IDLE, locked=0, counters and pending flags cleared. Sticky errors, good_count and last_period are retained.
- Sticky errors: clear_err clears them. If a new error sets in the same cycle as clear_err, the set wins.
- Back-to-back pulses (F and the next R in adjacent cycles) are legal. F and R never coincide.

## Timing
- Every output is registered.
- A pulse falls at cycle F (pulse_in low). pulse_ok, width_err/period_err and the locked change become visible in cycle F+1.
- last_period updates in cycle R+1.
- timeout_err rises one cycle after the counter reaches TIMEOUT. The state reads HUNT in that same cycle.
- Minimum detectable period: 2. Minimum width: 1.
- Asserting rst mid-pulse returns every output to 0 immediately. After release, the checker restarts in IDLE.

## Test plan
- Reset then enable; pulse width 1 every 11 cycles for 5 pulses:
  - pulse_ok on each pulse at F+1.
  - locked rises at F+1 of pulse 3.
  - good_count=5, last_period=11, no errors.
- Locked stream, then one pulse with width 2:
  - width_err set.
  - locked drops at F+1; no pulse_ok for that pulse.
  - Relocks after 3 further good pulses; good_count excludes the bad pulse.
- Period 12 with PERIOD_TOL=0:
  - period_err set, last_period=12, state TRACK.
  - The same stimulus with PERIOD_TOL=1 passes cleanly.
- Locked, then pulse_in held low:
  - timeout_err rises 33 cycles after the last R.
  - locked=0; the next pulse is accepted as the reference in TRACK.
- clear_err pulsed in the same cycle as a new width error: width_err stays 1. clear_err alone later: width_err returns to 0.
- Stimulus:
  - enable dropped mid-stream: locked=0, good_count held.
  - rst asserted mid-pulse: all outputs 0 asynchronously.
- Required response: after re-enable and 3 good pulses, locked=1.
